// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decoder with a valid/ready output
// register and a countdown that blocks new ops while a MUL/DIV is in flight.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   -> op_sel[3]==1 (other than load/store/beq) decodes to alu_ctrl=0
//                and raises the registered 'illegal' output.
//   undefined -> those op_sel values use the default {100, op_sel[2:0]} mapping
//                and the 'illegal' port does not exist.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   flush                 synchronous drop of pending output and in-flight op
//   in_valid, in_ready    input handshake (in_ready is combinational)
//   funct, op_sel         instruction fields to decode
//   out_valid, out_ready  output handshake
//   alu_ctrl, out_multi   registered control word and multi-cycle flag
//   busy                  multi-cycle countdown still running
//   mc_done               one-cycle pulse when a multi-cycle op finishes
//   illegal               (ILLEGAL_TRAP_EN) alu_ctrl is an illegal op
module alu_ctrl_seq #(
    parameter int unsigned          FUNCT_W   = 6,
    parameter int unsigned          OPSEL_W   = 4,
    parameter int unsigned          CTRL_W    = 6,
    parameter logic [FUNCT_W-1:0]   MUL_FUNCT = FUNCT_W'(6'b011000),
    parameter logic [FUNCT_W-1:0]   DIV_FUNCT = FUNCT_W'(6'b011010),
    parameter int unsigned          MUL_CYC   = 4,
    parameter int unsigned          DIV_CYC   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [OPSEL_W-1:0] op_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alu_ctrl,
    output logic               out_multi,
    output logic               busy,
    output logic               mc_done
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic               illegal
`endif
);

    localparam int unsigned MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [OPSEL_W-1:0] OP_RTYPE = '0;
    localparam logic [OPSEL_W-1:0] OP_LOAD  = OPSEL_W'(4'b1010);
    localparam logic [OPSEL_W-1:0] OP_STORE = OPSEL_W'(4'b1011);
    localparam logic [OPSEL_W-1:0] OP_BEQ   = OPSEL_W'(4'b1100);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CTRL_W-1:0]  dec_ctrl;
    logic               dec_multi;
    logic [CNT_W-1:0]   dec_load;
    logic               accept;
`ifdef ILLEGAL_TRAP_EN
    logic               dec_illegal;
`endif

    // Combinational decode of the incoming fields; only loaded on accept,
    // so X on idle inputs never reaches a register.
    always_comb begin
        dec_ctrl  = CTRL_W'({3'b100, op_sel[2:0]});
        dec_multi = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        dec_illegal = 1'b0;
`endif
        if (op_sel == OP_RTYPE) begin
            dec_ctrl  = CTRL_W'(funct);
            dec_multi = (funct == MUL_FUNCT) || (funct == DIV_FUNCT);
        end else if (op_sel == OP_LOAD) begin
            dec_ctrl = CTRL_W'(6'b001110);
        end else if (op_sel == OP_STORE) begin
            dec_ctrl = CTRL_W'(6'b011110);
        end else if (op_sel == OP_BEQ) begin
            dec_ctrl = CTRL_W'(6'b000000);
        end
`ifdef ILLEGAL_TRAP_EN
        else if (op_sel[3]) begin
            dec_ctrl    = '0;
            dec_illegal = 1'b1;
        end
`endif
    end

    // Countdown reload value: occupancy minus the accept cycle itself.
    always_comb begin
        dec_load = (funct == MUL_FUNCT) ? CNT_W'(MUL_CYC - 1) : CNT_W'(DIV_CYC - 1);
    end

    assign in_ready = !flush && !busy && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Output register: load on accept (also covers same-cycle handshake
    // reload), clear valid on handshake, drop on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            alu_ctrl  <= '0;
            out_multi <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal   <= 1'b0;
`endif
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_ctrl  <= dec_ctrl;
            out_multi <= dec_multi;
`ifdef ILLEGAL_TRAP_EN
            illegal   <= dec_illegal;
`endif
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Countdown FSM; busy/mc_done are registered from the values the
    // state and counter take at the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            mc_done <= 1'b0;
        end else if (flush) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            mc_done <= 1'b0;
        end else if (accept && dec_multi) begin
            state   <= ST_BUSY;
            cnt     <= dec_load;
            busy    <= (dec_load != '0);
            mc_done <= (dec_load == '0);
        end else if (state == ST_BUSY) begin
            if (cnt == '0) begin
                state   <= ST_IDLE;
                busy    <= 1'b0;
                mc_done <= 1'b0;
            end else begin
                cnt     <= cnt - CNT_W'(1);
                busy    <= (cnt != CNT_W'(1));
                mc_done <= (cnt == CNT_W'(1));
            end
        end else begin
            busy    <= 1'b0;
            mc_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq: a driver issues directed and random
// ops and pushes expected control words; a monitor pops them on each output
// handshake. Busy/mc_done are predicted from a per-op completion cycle.
module tb_alu_ctrl_seq;

    localparam int unsigned MUL_CYC = 4;
    localparam int unsigned DIV_CYC = 16;
    localparam logic [5:0]  MULF    = 6'b011000;
    localparam logic [5:0]  DIVF    = 6'b011010;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] funct;
    logic [3:0] op_sel;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] alu_ctrl;
    logic       out_multi;
    logic       busy;
    logic       mc_done;
    logic       illegal_w;

    alu_ctrl_seq #(
        .FUNCT_W(6), .OPSEL_W(4), .CTRL_W(6),
        .MUL_FUNCT(MULF), .DIV_FUNCT(DIVF),
        .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .op_sel(op_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .out_multi(out_multi),
        .busy(busy), .mc_done(mc_done)
`ifdef ILLEGAL_TRAP_EN
        , .illegal(illegal_w)
`endif
    );

`ifndef ILLEGAL_TRAP_EN
    assign illegal_w = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] ctrl;
        bit         multi;
        bit         ill;
    } exp_t;

    exp_t sb[$];
    int   cycle   = 0;
    int   done_at = -1;
    int   errors  = 0;
    int   checks  = 0;
    bit   run     = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cycle);
        end
    endfunction

    // Reference decode straight from the opcode table.
    function automatic exp_t ref_decode(logic [5:0] f, logic [3:0] o);
        exp_t e;
        e.multi = 1'b0;
        e.ill   = 1'b0;
        case (o)
            4'b0000: begin
                e.ctrl  = f;
                e.multi = (f == MULF) || (f == DIVF);
            end
            4'b1010: e.ctrl = 6'b001110;
            4'b1011: e.ctrl = 6'b011110;
            4'b1100: e.ctrl = 6'b000000;
            default: begin
                e.ctrl = {3'b100, o[2:0]};
`ifdef ILLEGAL_TRAP_EN
                if (o[3]) begin
                    e.ctrl = 6'b000000;
                    e.ill  = 1'b1;
                end
`endif
            end
        endcase
        return e;
    endfunction

    // One cycle of stimulus: drive at negedge, predict in_ready, record accept.
    task automatic step(input bit v, input logic [5:0] f, input logic [3:0] o,
                        input bit ordy, input bit fl);
        bit   exp_busy;
        bit   exp_rdy;
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        funct     = v ? f : 6'bx;
        op_sel    = v ? o : 4'bx;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_busy = (done_at >= 0) && (cycle < done_at);
        exp_rdy  = !fl && !exp_busy && ((sb.size() == 0) || ordy);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (fl) begin
            done_at = -1;
        end else if (v && exp_rdy) begin
            e = ref_decode(f, o);
            sb.push_back(e);
            if (e.multi)
                done_at = cycle + ((f == MULF) ? int'(MUL_CYC) : int'(DIV_CYC));
        end
    endtask

    // Monitor: registered outputs vs model, pop on handshake.
    always @(negedge clk) begin
        if (run && rst_n) begin
            chk("busy", 32'(busy), 32'((done_at >= 0) && (cycle < done_at)));
            chk("mc_done", 32'(mc_done), 32'(cycle == done_at));
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (out_valid && sb.size() != 0) begin
                chk("alu_ctrl", 32'(alu_ctrl), 32'(sb[0].ctrl));
                chk("out_multi", 32'(out_multi), 32'(sb[0].multi));
                chk("illegal", 32'(illegal_w), 32'(sb[0].ill));
            end
            #2;
            if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
            if (flush) sb.delete();
        end
    end

    task automatic check_all_zero(string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_alu_ctrl"},  32'(alu_ctrl),  32'd0);
        chk({tag, "_out_multi"}, 32'(out_multi), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_mc_done"},   32'(mc_done),   32'd0);
        chk({tag, "_illegal"},   32'(illegal_w), 32'd0);
    endtask

    initial begin
        logic [5:0] rf;
        logic [3:0] ro;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        funct     = 6'd0;
        op_sel    = 4'd0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        run   = 1'b1;

        // Fixed decodes, back-to-back with out_ready held high.
        step(1, 6'h00, 4'b1010, 1, 0);
        step(1, 6'h00, 4'b1011, 1, 0);
        step(1, 6'h00, 4'b1100, 1, 0);
        step(1, 6'h00, 4'b0101, 1, 0);
        step(1, 6'h00, 4'b1111, 1, 0);
        step(0, 6'h00, 4'b0000, 1, 0);

        // MUL: blocked three cycles, new op taken in the mc_done cycle.
        step(1, MULF, 4'b0000, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 6'h20, 4'b0000, 1, 0);
        step(0, 6'h00, 4'b0000, 1, 0);

        // Stall: output must hold while out_ready is low.
        step(1, 6'b100000, 4'b0000, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 6'h11, 4'b0001, 0, 0);
        step(0, 6'h00, 4'b0000, 1, 0);
        step(0, 6'h00, 4'b0000, 1, 0);

        // DIV then flush with a competing op at cnt==7.
        step(1, DIVF, 4'b0000, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 6'h00, 4'b0000, 1, 0);
        step(1, 6'h05, 4'b0000, 1, 1);
        for (int i = 0; i < 20; i++) step(0, 6'h00, 4'b0000, 1, 0);

        // Asynchronous reset in the middle of a DIV (cnt==9).
        step(1, DIVF, 4'b0000, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 6'h00, 4'b0000, 1, 0);
        #2;
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        sb.delete();
        done_at = -1;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        step(1, 6'h00, 4'b1010, 1, 0);
        step(0, 6'h00, 4'b0000, 1, 0);

        // Random traffic.
        for (int i = 0; i < 900; i++) begin
            case ($urandom_range(0, 4))
                0: begin rf = MULF; ro = 4'b0000; end
                1: begin rf = DIVF; ro = 4'b0000; end
                2: begin rf = 6'($urandom); ro = 4'b0000; end
                default: begin rf = 6'($urandom); ro = 4'($urandom); end
            endcase
            step($urandom_range(0, 3) != 0, rf, ro,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end

        // Drain and confirm nothing is left over.
        for (int i = 0; i < 25; i++) step(0, 6'h00, 4'b0000, 1, 0);
        chk("drained", 32'(sb.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
